// File: rtl/write_resp_router.sv
// write_resp_router
//   Routes AXI write responses (B channel) from two slaves to two masters.
//   One response is in flight at a time: a slave is granted in IDLE
//   (round-robin on ties), its B beat is steered to the master selected by
//   bid[0], and the grant is held until the B handshake completes.
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   s0_*/s1_*                B channel from slave 0/1 (bid, bresp, bvalid in; bready out)
//   m0_*/m1_*                B channel to master 0/1 (bid, bresp, bvalid out; bready in)
//   busy                     high while a grant is held
//   grant_slave              index of the granted slave (valid while busy)
//   resp_count               completed B handshakes, wraps silently
module write_resp_router #(
    parameter int ID_W  = 1,
    parameter int CNT_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ID_W-1:0]   s0_bid,
    input  logic [1:0]        s0_bresp,
    input  logic              s0_bvalid,
    output logic              s0_bready,

    input  logic [ID_W-1:0]   s1_bid,
    input  logic [1:0]        s1_bresp,
    input  logic              s1_bvalid,
    output logic              s1_bready,

    output logic [ID_W-1:0]   m0_bid,
    output logic [1:0]        m0_bresp,
    output logic              m0_bvalid,
    input  logic              m0_bready,

    output logic [ID_W-1:0]   m1_bid,
    output logic [1:0]        m1_bresp,
    output logic              m1_bvalid,
    input  logic              m1_bready,

    output logic              busy,
    output logic              grant_slave,
    output logic [CNT_W-1:0]  resp_count
);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t           state;
    logic             last_grant;
    logic             tgt;
    logic [ID_W-1:0]  bid_q;

    logic             sel_bvalid;
    logic [1:0]       sel_bresp;
    logic             sel_bready;
    logic             handshake;

    // Granted slave's B beat and target master's ready; zero outside GRANT
    // so every routed output falls to 0 as soon as state resets.
    always_comb begin
        sel_bvalid = 1'b0;
        sel_bresp  = '0;
        sel_bready = 1'b0;
        if (state == GRANT) begin
            sel_bvalid = grant_slave ? s1_bvalid : s0_bvalid;
            sel_bresp  = grant_slave ? s1_bresp  : s0_bresp;
            sel_bready = tgt ? m1_bready : m0_bready;
        end
    end

    assign handshake = sel_bvalid & sel_bready;

    always_comb begin
        m0_bvalid = 1'b0;
        m0_bresp  = '0;
        m0_bid    = '0;
        m1_bvalid = 1'b0;
        m1_bresp  = '0;
        m1_bid    = '0;
        s0_bready = 1'b0;
        s1_bready = 1'b0;
        if (state == GRANT) begin
            if (tgt) begin
                m1_bvalid = sel_bvalid;
                m1_bresp  = sel_bresp;
                m1_bid    = bid_q;
            end else begin
                m0_bvalid = sel_bvalid;
                m0_bresp  = sel_bresp;
                m0_bid    = bid_q;
            end
            if (grant_slave) s1_bready = sel_bready;
            else             s0_bready = sel_bready;
        end
    end

    assign busy = (state == GRANT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            last_grant  <= 1'b1;
            grant_slave <= 1'b0;
            tgt         <= 1'b0;
            bid_q       <= '0;
            resp_count  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (s0_bvalid && (!s1_bvalid || last_grant)) begin
                        state       <= GRANT;
                        grant_slave <= 1'b0;
                        tgt         <= s0_bid[0];
                        bid_q       <= s0_bid;
                    end else if (s1_bvalid) begin
                        state       <= GRANT;
                        grant_slave <= 1'b1;
                        tgt         <= s1_bid[0];
                        bid_q       <= s1_bid;
                    end
                end
                GRANT: begin
                    if (handshake) begin
                        state      <= IDLE;
                        last_grant <= grant_slave;
                        resp_count <= resp_count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_write_resp_router.sv
// tb_write_resp_router
//   Directed bench for write_resp_router: reset values, single routing,
//   round-robin alternation, master backpressure, bvalid drop mid-grant,
//   asynchronous reset mid-grant and counter wrap.
module tb_write_resp_router;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [0:0] s0_bid = '0, s1_bid = '0;
    logic [1:0] s0_bresp = '0, s1_bresp = '0;
    logic       s0_bvalid = 1'b0, s1_bvalid = 1'b0;
    logic       s0_bready, s1_bready;
    logic [0:0] m0_bid, m1_bid;
    logic [1:0] m0_bresp, m1_bresp;
    logic       m0_bvalid, m1_bvalid;
    logic       m0_bready = 1'b0, m1_bready = 1'b0;
    logic       busy, grant_slave;
    logic [7:0] resp_count;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [7:0]  exp_cnt = '0;

    write_resp_router #(.ID_W(1), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .s0_bid(s0_bid), .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s1_bid(s1_bid), .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .m0_bid(m0_bid), .m0_bresp(m0_bresp), .m0_bvalid(m0_bvalid), .m0_bready(m0_bready),
        .m1_bid(m1_bid), .m1_bresp(m1_bresp), .m1_bvalid(m1_bvalid), .m1_bready(m1_bready),
        .busy(busy), .grant_slave(grant_slave), .resp_count(resp_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance past the next rising edge; inputs are driven and outputs sampled here.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        step();
        step();
        rst = 1'b1;
        exp_cnt = '0;
    endtask

    initial begin
        // Reset values
        #12;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_cnt", 32'(resp_count), 0);
        chk("rst_gs", 32'(grant_slave), 0);
        chk("rst_m0v", 32'(m0_bvalid), 0);
        chk("rst_m1v", 32'(m1_bvalid), 0);
        rst = 1'b1;
        step();

        // Single response s0 -> m1
        s0_bvalid = 1'b1; s0_bid = 1'b1; s0_bresp = 2'b10; m1_bready = 1'b1;
        chk("idle_m1v", 32'(m1_bvalid), 0);
        chk("idle_s0r", 32'(s0_bready), 0);
        step();
        chk("r35_m1v", 32'(m1_bvalid), 1);
        chk("r35_m1resp", 32'(m1_bresp), 2);
        chk("r35_m1bid", 32'(m1_bid), 1);
        chk("r35_s0r", 32'(s0_bready), 1);
        chk("r35_m0v", 32'(m0_bvalid), 0);
        chk("r35_busy", 32'(busy), 1);
        step();
        s0_bvalid = 1'b0;
        exp_cnt++;
        chk("r35_busy2", 32'(busy), 0);
        chk("r35_cnt", 32'(resp_count), 32'(exp_cnt));
        chk("r35_s0r2", 32'(s0_bready), 0);

        // Round-robin alternation
        do_reset();
        s0_bvalid = 1'b1; s0_bid = 1'b0; s0_bresp = 2'b01;
        s1_bvalid = 1'b1; s1_bid = 1'b1; s1_bresp = 2'b11;
        m0_bready = 1'b1; m1_bready = 1'b1;
        step();
        chk("rr1_gs", 32'(grant_slave), 0);
        chk("rr1_m0v", 32'(m0_bvalid), 1);
        chk("rr1_m0resp", 32'(m0_bresp), 1);
        chk("rr1_s0r", 32'(s0_bready), 1);
        chk("rr1_s1r", 32'(s1_bready), 0);
        chk("rr1_m1v", 32'(m1_bvalid), 0);
        step();
        exp_cnt++;
        chk("rr1_idle", 32'(busy), 0);
        step();
        chk("rr2_gs", 32'(grant_slave), 1);
        chk("rr2_m1v", 32'(m1_bvalid), 1);
        chk("rr2_m1resp", 32'(m1_bresp), 3);
        chk("rr2_m1bid", 32'(m1_bid), 1);
        chk("rr2_s1r", 32'(s1_bready), 1);
        chk("rr2_s0r", 32'(s0_bready), 0);
        step();
        exp_cnt++;
        step();
        chk("rr3_gs", 32'(grant_slave), 0);
        chk("rr3_busy", 32'(busy), 1);
        step();
        exp_cnt++;
        chk("rr3_cnt", 32'(resp_count), 32'(exp_cnt));

        // Slave 1 granted to master 0 under backpressure
        s1_bid = 1'b0; s1_bresp = 2'b10; m0_bready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_m0v", 32'(m0_bvalid), 1);
            chk("bp_m0resp", 32'(m0_bresp), 2);
            chk("bp_s1r", 32'(s1_bready), 0);
            chk("bp_s0r", 32'(s0_bready), 0);
            chk("bp_busy", 32'(busy), 1);
            chk("bp_gs", 32'(grant_slave), 1);
            step();
        end
        chk("bp_cnt_hold", 32'(resp_count), 32'(exp_cnt));
        m0_bready = 1'b1;
        #1;
        chk("bp_s1r_go", 32'(s1_bready), 1);
        step();
        exp_cnt++;
        s1_bvalid = 1'b0;
        chk("bp_done", 32'(busy), 0);
        chk("bp_cnt", 32'(resp_count), 32'(exp_cnt));

        // bvalid drops during GRANT
        m0_bready = 1'b0;
        step();
        chk("drop_m0v", 32'(m0_bvalid), 1);
        chk("drop_gs", 32'(grant_slave), 0);
        s0_bvalid = 1'b0;
        #1;
        chk("drop_m0v0", 32'(m0_bvalid), 0);
        chk("drop_busy", 32'(busy), 1);
        step();
        m0_bready = 1'b1;
        step();
        chk("drop_busy2", 32'(busy), 1);
        chk("drop_cnt", 32'(resp_count), 32'(exp_cnt));
        s0_bvalid = 1'b1;
        #1;
        chk("drop_m0v1", 32'(m0_bvalid), 1);
        chk("drop_s0r", 32'(s0_bready), 1);
        step();
        exp_cnt++;
        s0_bvalid = 1'b0;
        chk("drop_done", 32'(busy), 0);
        chk("drop_cnt2", 32'(resp_count), 32'(exp_cnt));

        // Asynchronous reset in the middle of a grant
        s0_bvalid = 1'b1; m0_bready = 1'b0;
        step();
        m0_bready = 1'b1;
        #1;
        chk("ar_s0r_pre", 32'(s0_bready), 1);
        chk("ar_m0v_pre", 32'(m0_bvalid), 1);
        rst = 1'b0;
        #1;
        chk("ar_s0r", 32'(s0_bready), 0);
        chk("ar_m0v", 32'(m0_bvalid), 0);
        chk("ar_m0resp", 32'(m0_bresp), 0);
        chk("ar_busy", 32'(busy), 0);
        chk("ar_cnt", 32'(resp_count), 0);
        step();
        rst = 1'b1;
        exp_cnt = '0;
        s1_bvalid = 1'b1; s1_bid = 1'b1;
        step();
        chk("ar_tie_gs", 32'(grant_slave), 0);
        chk("ar_tie_busy", 32'(busy), 1);
        step();
        exp_cnt++;
        s0_bvalid = 1'b0; s1_bvalid = 1'b0;
        chk("ar_cnt1", 32'(resp_count), 32'(exp_cnt));

        // Counter wrap over 256 back-to-back responses
        do_reset();
        s0_bvalid = 1'b1; s0_bid = 1'b0; m0_bready = 1'b1;
        for (int i = 0; i < 256; i++) begin
            step();
            chk("wrap_m0v", 32'(m0_bvalid), 1);
            chk("wrap_m1v", 32'(m1_bvalid), 0);
            step();
            exp_cnt++;
            chk("wrap_idle", 32'(busy), 0);
            if (i == 254) chk("wrap_255", 32'(resp_count), 255);
        end
        s0_bvalid = 1'b0;
        chk("wrap_cnt", 32'(resp_count), 32'(exp_cnt));
        chk("wrap_zero", 32'(resp_count), 0);
        step();
        chk("wrap_final_busy", 32'(busy), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
